// File: rtl/ov2640_config_ctrl.sv
// OV2640 start-up configuration sequencer.
// Walks a registered register LUT and turns each {reg_addr, reg_data} entry
// into one SCCB write. It waits after power-up, waits longer after a COM7 soft
// reset write, and leaves an idle gap between writes.
//
// Handshakes:
// - lut_resend_o and lut_advance_o are single-cycle pulses.
// - lut_command_i and lut_finished_i are sampled only in S_CHECK, after
//   LUT_SETTLE settle cycles.
// - sccb_start_o is a single-cycle pulse. It is issued only while
//   sccb_ready_i is high.
// - sccb_addr_o and sccb_data_o are held stable from sccb_start_o until the
//   write ends, either on sccb_done_i or on a timeout.
// - sccb_done_i is honoured only in S_WAITDONE.
module ov2640_config_ctrl #(
    parameter int unsigned POWERUP_CYCLES = 270000,
    parameter int unsigned RESET_CYCLES   = 27000,
    parameter int unsigned GAP_CYCLES     = 270,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned LUT_SETTLE     = 2,
    parameter logic [7:0]  SCCB_ID        = 8'h60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart_i,
    output logic        lut_resend_o,
    output logic        lut_advance_o,
    input  logic [15:0] lut_command_i,
    input  logic        lut_finished_i,
    input  logic        sccb_ready_i,
    output logic        sccb_start_o,
    output logic [7:0]  sccb_id_o,
    output logic [7:0]  sccb_addr_o,
    output logic [7:0]  sccb_data_o,
    input  logic        sccb_done_i,
    output logic        config_done_o,
    output logic        busy_o,
    output logic        cfg_error_o,
    output logic [8:0]  reg_count_o,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_PWRUP    = 4'd0,
        S_RESEND   = 4'd1,
        S_SETTLE   = 4'd2,
        S_CHECK    = 4'd3,
        S_WAITRDY  = 4'd4,
        S_WAITDONE = 4'd5,
        S_GAP      = 4'd6,
        S_ADV      = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    // Every wait ends when the counter hits zero, so each load value is the
    // cycle count minus one. The one exception is the power-up wait: the
    // counter resets to zero, so this wait counts up to its last value.
    localparam logic [23:0] PWRUP_LAST   = 24'(POWERUP_CYCLES - 1);
    localparam logic [23:0] RESET_LAST   = 24'(RESET_CYCLES - 1);
    localparam logic [23:0] GAP_LAST     = 24'(GAP_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] SETTLE_LAST  = 24'(LUT_SETTLE - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        err_q, err_d;
    logic [8:0]  count_q, count_d;
    logic        pend_q, pend_d;
    logic        resend_q, resend_d;
    logic        advance_q, advance_d;
    logic        start_q, start_d;
    logic        cdone_q, cdone_d;
    logic        busy_q, busy_d;

    // Next-state logic: sequencing, the shared wait counter and the latched write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        count_d = count_q;
        pend_d  = pend_q;

        // A restart while busy waits for the current frame to finish.
        // A restart during power-up has no effect.
        if (restart_i && state_q != S_PWRUP && state_q != S_DONE) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RESEND;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_RESEND: begin
                cnt_d   = SETTLE_LAST;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_CHECK: begin
                if (lut_finished_i) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = lut_command_i[15:8];
                    data_d  = lut_command_i[7:0];
                    state_d = S_WAITRDY;
                end
            end
            S_WAITRDY: begin
                if (sccb_ready_i) begin
                    cnt_d = TIMEOUT_LAST;
                    if (count_q != 9'h1FF) begin
                        count_d = count_q + 9'd1;
                    end
                    state_d = S_WAITDONE;
                end
            end
            S_WAITDONE: begin
                // If done and expiry land on the same cycle, done wins.
                if (sccb_done_i || cnt_q == '0) begin
                    if (!sccb_done_i) begin
                        err_d = 1'b1;
                    end
                    // The gap length is loaded on entry. A COM7 soft reset
                    // gets the long wait.
                    cnt_d   = (addr_q == 8'h12 && data_q[7]) ? RESET_LAST : GAP_LAST;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = pend_q ? S_RESEND : S_ADV;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_ADV: begin
                cnt_d   = SETTLE_LAST;
                state_d = S_SETTLE;
            end
            S_DONE: begin
                if (restart_i || pend_q) begin
                    state_d = S_RESEND;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_PWRUP;
            end
        endcase

        // Each new run starts with clean statistics. They are cleared on
        // entry so that they read zero while lut_resend_o is high.
        if (state_d == S_RESEND) begin
            count_d = '0;
            err_d   = 1'b0;
            pend_d  = 1'b0;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_comb begin
        resend_d  = (state_d == S_RESEND);
        advance_d = (state_d == S_ADV);
        start_d   = (state_q == S_WAITRDY) && (state_d == S_WAITDONE);
        cdone_d   = (state_d == S_DONE);
        busy_d    = (state_d != S_DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PWRUP;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            count_q   <= '0;
            pend_q    <= 1'b0;
            resend_q  <= 1'b0;
            advance_q <= 1'b0;
            start_q   <= 1'b0;
            cdone_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            resend_q  <= resend_d;
            advance_q <= advance_d;
            start_q   <= start_d;
            cdone_q   <= cdone_d;
            busy_q    <= busy_d;
        end
    end

    assign lut_resend_o  = resend_q;
    assign lut_advance_o = advance_q;
    assign sccb_start_o  = start_q;
    assign sccb_id_o     = SCCB_ID;
    assign sccb_addr_o   = addr_q;
    assign sccb_data_o   = data_q;
    assign config_done_o = cdone_q;
    assign busy_o        = busy_q;
    assign cfg_error_o   = err_q;
    assign reg_count_o   = count_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ov2640_config_ctrl.sv
// Bench for ov2640_config_ctrl: 4-entry LUT model, SCCB responder model,
// scoreboard of expected SCCB writes, and directed scenarios.
module tb_ov2640_config_ctrl;

  localparam int PWR        = 20;
  localparam int RSTW       = 50;
  localparam int GAPW       = 5;
  localparam int TMO        = 100;
  localparam int DONE_DELAY = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart_i = 1'b0;
  logic        lut_resend_o, lut_advance_o;
  logic [15:0] lut_command_i;
  logic        lut_finished_i;
  logic        sccb_ready_i;
  logic        sccb_start_o;
  logic [7:0]  sccb_id_o, sccb_addr_o, sccb_data_o;
  logic        sccb_done_i = 1'b0;
  logic        config_done_o, busy_o, cfg_error_o;
  logic [8:0]  reg_count_o;
  logic [3:0]  state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];

  ov2640_config_ctrl #(
    .POWERUP_CYCLES(PWR), .RESET_CYCLES(RSTW), .GAP_CYCLES(GAPW),
    .TIMEOUT_CYCLES(TMO), .LUT_SETTLE(2), .SCCB_ID(8'h60)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart_i(restart_i),
    .lut_resend_o(lut_resend_o), .lut_advance_o(lut_advance_o),
    .lut_command_i(lut_command_i), .lut_finished_i(lut_finished_i),
    .sccb_ready_i(sccb_ready_i), .sccb_start_o(sccb_start_o),
    .sccb_id_o(sccb_id_o), .sccb_addr_o(sccb_addr_o), .sccb_data_o(sccb_data_o),
    .sccb_done_i(sccb_done_i), .config_done_o(config_done_o), .busy_o(busy_o),
    .cfg_error_o(cfg_error_o), .reg_count_o(reg_count_o), .state_o(state_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // LUT model: registered address, registered output, two-cycle latency.
  logic [15:0] lut_rom [4] = '{16'hFF01, 16'h1280, 16'h1180, 16'hFFFF};
  logic [1:0]  lut_addr = 2'd0;
  logic [15:0] lut_cmd = 16'hFFFF;
  always @(posedge clk) begin
    if (lut_resend_o) lut_addr <= 2'd0;
    else if (lut_advance_o && lut_addr != 2'd3) lut_addr <= lut_addr + 2'd1;
    lut_cmd <= lut_rom[lut_addr];
  end
  assign lut_command_i  = lut_cmd;
  assign lut_finished_i = (lut_cmd == 16'hFFFF);

  // SCCB responder: answers DONE_DELAY cycles after a start, except for start
  // number no_answer_num of the run. A pending answer survives a DUT reset.
  bit          ready_en = 1'b1;
  int          no_answer_num = 0;
  int          m_start = 0;
  int          pend_cnt = 0;
  int          done_cyc = 0;
  logic [7:0]  done_addr = 8'h00, done_data = 8'h00;
  bit          done_seen = 1'b0;
  assign sccb_ready_i = ready_en && (pend_cnt == 0);

  always @(negedge clk) begin
    sccb_done_i = 1'b0;
    if (rst_n && sccb_start_o) begin
      m_start++;
      if (m_start != no_answer_num) pend_cnt = DONE_DELAY;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        sccb_done_i = 1'b1;
        done_cyc    = cyc;
        done_addr   = sccb_addr_o;
        done_data   = sccb_data_o;
        done_seen   = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  int  n_start = 0;
  int  tmo_start_cyc = 0;
  bit  err_prev = 1'b0;
  bit  resend_seen = 1'b0;
  int  first_resend_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sccb_start_o) begin
        n_start++;
        if (n_start == no_answer_num) tmo_start_cyc = cyc;
        check("sccb_id", 32'(sccb_id_o), 32'h60);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sccb_write_unexpected actual=%h expected=none", {sccb_addr_o, sccb_data_o});
        end else begin
          check("sccb_write", 32'({sccb_addr_o, sccb_data_o}), 32'(exp_q.pop_front()));
        end
      end
      if (lut_resend_o || lut_advance_o)
        check("resend_advance_exclusive", 32'(lut_resend_o & lut_advance_o), 32'd0);
      if (lut_resend_o && !resend_seen) begin
        resend_seen      = 1'b1;
        first_resend_cyc = cyc;
      end
      if (lut_advance_o && done_seen) begin
        check("gap_idle_cycles", 32'(cyc - done_cyc - 1),
              (done_addr == 8'h12 && done_data[7]) ? 32'(RSTW) : 32'(GAPW));
        done_seen = 1'b0;
      end
      if (cfg_error_o && !err_prev && no_answer_num > 0)
        check("timeout_cycles", 32'(cyc - tmo_start_cyc), 32'(TMO));
      err_prev = cfg_error_o;
    end else begin
      err_prev = 1'b0;
    end
  end

  // driver tasks
  int rel_cyc = 0;

  task automatic push_run();
    exp_q.push_back(16'hFF01);
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1180);
  endtask

  task automatic release_reset();
    n_start     = 0;
    m_start     = 0;
    resend_seen = 1'b0;
    rst_n       = 1'b1;
    rel_cyc     = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    pend_cnt  = 0;
    done_seen = 1'b0;
    exp_q.delete();
    release_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_resend"},  32'(lut_resend_o),  32'd0);
    check({tag, "_advance"}, 32'(lut_advance_o), 32'd0);
    check({tag, "_start"},   32'(sccb_start_o),  32'd0);
    check({tag, "_addr"},    32'(sccb_addr_o),   32'd0);
    check({tag, "_data"},    32'(sccb_data_o),   32'd0);
    check({tag, "_cdone"},   32'(config_done_o), 32'd0);
    check({tag, "_busy"},    32'(busy_o),        32'd1);
    check({tag, "_err"},     32'(cfg_error_o),   32'd0);
    check({tag, "_count"},   32'(reg_count_o),   32'd0);
  endtask

  task automatic wait_cfg_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (config_done_o) break;
    end
    check({tag, "_config_done"}, 32'(config_done_o), 32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_start >= n) break;
      @(negedge clk);
    end
    check("wait_start_count", 32'(n_start), 32'(n));
  endtask

  initial begin
    // 1/2: nominal run, gaps
    no_answer_num = 0;
    ready_en = 1'b1;
    do_reset();
    @(negedge clk);
    check_reset_vals("reset");
    push_run();
    wait_cfg_done("nominal", 2000);
    check("nominal_first_resend_ge_pwrup", 32'(first_resend_cyc - rel_cyc >= PWR), 32'd1);
    check("nominal_reg_count", 32'(reg_count_o), 32'd3);
    check("nominal_cfg_error", 32'(cfg_error_o), 32'd0);
    check("nominal_starts", 32'(n_start), 32'd3);

    // 3: timeout on second write
    no_answer_num = 2;
    do_reset();
    push_run();
    wait_cfg_done("timeout", 2000);
    check("timeout_cfg_error", 32'(cfg_error_o), 32'd1);
    check("timeout_reg_count", 32'(reg_count_o), 32'd3);

    // 4: ready stall
    no_answer_num = 0;
    ready_en = 1'b0;
    do_reset();
    push_run();
    repeat (300) @(negedge clk);
    check("stall_no_start", 32'(n_start), 32'd0);
    ready_en = 1'b1;
    wait_cfg_done("stall", 2000);
    check("stall_cfg_error", 32'(cfg_error_o), 32'd0);
    check("stall_reg_count", 32'(reg_count_o), 32'd3);

    // 5: restart during second write; first write times out so the clear shows
    no_answer_num = 1;
    do_reset();
    exp_q.push_back(16'hFF01);
    exp_q.push_back(16'h1280);
    push_run();
    wait_starts(2, 2000);
    repeat (3) @(negedge clk);
    check("restart_err_before", 32'(cfg_error_o), 32'd1);
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    resend_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (resend_seen) break;
      @(negedge clk);
    end
    check("restart_resend_seen", 32'(resend_seen), 32'd1);
    check("restart_count_cleared", 32'(reg_count_o), 32'd0);
    check("restart_err_cleared", 32'(cfg_error_o), 32'd0);
    wait_cfg_done("restart", 2000);
    check("restart_reg_count", 32'(reg_count_o), 32'd3);
    check("restart_cfg_error", 32'(cfg_error_o), 32'd0);
    check("restart_starts", 32'(n_start), 32'd5);

    // 6: async reset mid-write; late done is ignored
    no_answer_num = 0;
    do_reset();
    push_run();
    wait_starts(1, 2000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    exp_q.delete();
    push_run();
    release_reset();
    for (int i = 0; i < 50; i++) begin
      if (pend_cnt == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("late_done_count", 32'(reg_count_o), 32'd0);
    check("late_done_busy", 32'(busy_o), 32'd1);
    check("late_done_no_resend", 32'(resend_seen), 32'd0);
    wait_cfg_done("after_reset", 2000);
    check("after_reset_reg_count", 32'(reg_count_o), 32'd3);
    check("after_reset_cfg_error", 32'(cfg_error_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
